// File: rtl/video_types.sv
// Shared LCD timing types and default timing constants for the whizgraphics renderer.
package video_types;

  typedef enum logic [1:0] {
    HBLANK = 2'd0,
    VBLANK = 2'd1,
    OAM    = 2'd2,
    XFER   = 2'd3
  } lcd_mode_t;

  localparam int unsigned DEF_DOTS_PER_LINE = 456;
  localparam int unsigned DEF_OAM_DOTS      = 80;
  localparam int unsigned DEF_MIN_XFER_DOTS = 172;
  localparam int unsigned DEF_VISIBLE_LINES = 144;
  localparam int unsigned DEF_TOTAL_LINES   = 154;

endpackage

// File: rtl/stat_irq_gen.sv
// STAT interrupt source combiner with a rising-edge detector; output is a registered one-cycle pulse.
module stat_irq_gen
  import video_types::*;
(
  input  logic      clk,
  input  logic      i_clear,
  input  logic [3:0] i_stat_en,
  input  lcd_mode_t i_mode,
  input  logic      i_lyc_match,
  output logic      o_stat_irq
);

  logic w_stat_line;
  logic r_prev;
  logic r_irq;

  always_comb begin
    w_stat_line = (i_stat_en[0] && (i_mode == HBLANK)) ||
                  (i_stat_en[1] && (i_mode == VBLANK)) ||
                  (i_stat_en[2] && (i_mode == OAM))    ||
                  (i_stat_en[3] && i_lyc_match);
  end

  // A line that stays high across a mode change yields no new pulse.
  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_prev <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      r_prev <= w_stat_line;
      r_irq  <= w_stat_line && !r_prev;
    end
  end

  assign o_stat_irq = r_irq;

endmodule

// File: rtl/lcd_mode_sequencer.sv
// LCD dot/line timing and mode sequencer with drawline handshake and CPU access gating.
// Optional STAT interrupt generation is enabled by defining WHIZ_STAT_IRQ_EN.
module lcd_mode_sequencer
  import video_types::*;
#(
  parameter int unsigned DOTS_PER_LINE = DEF_DOTS_PER_LINE,
  parameter int unsigned OAM_DOTS      = DEF_OAM_DOTS,
  parameter int unsigned MIN_XFER_DOTS = DEF_MIN_XFER_DOTS,
  parameter int unsigned VISIBLE_LINES = DEF_VISIBLE_LINES,
  parameter int unsigned TOTAL_LINES   = DEF_TOTAL_LINES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_enable,
  input  logic [7:0] lyc,
  input  logic [3:0] stat_en,
  input  logic       render_done,
  output logic       drawline,
  output logic [7:0] ly,
  output logic [8:0] dot,
  output lcd_mode_t  mode,
  output logic       lyc_match,
  output logic       vram_cpu_ok,
  output logic       oam_cpu_ok,
  output logic       vblank_irq,
  output logic       stat_irq,
  output logic       overrun
);

  localparam logic [8:0] DOT_LAST = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] DOT_XFER = 9'(OAM_DOTS);
  localparam logic [8:0] DOT_XMIN = 9'(OAM_DOTS + MIN_XFER_DOTS - 1);
  localparam logic [7:0] LY_LAST  = 8'(TOTAL_LINES - 1);
  localparam logic [7:0] LY_VBL   = 8'(VISIBLE_LINES);

  logic      r_run;
  logic [8:0] r_dot;
  logic [7:0] r_ly;
  lcd_mode_t r_mode;
  logic      r_done;
  logic      r_drawline;
  logic      r_vblank_irq;
  logic      r_vram_ok;
  logic      r_oam_ok;
  logic      r_overrun;
  logic      r_lyc_match;

  logic      w_line_end;
  logic      w_xfer_exit;
  logic [8:0] w_ndot;
  logic [7:0] w_nly;
  lcd_mode_t w_nmode;
  logic      w_stat_clear;

  // Next-state view: the first enabled cycle lands on line 0 dot 0 rather than advancing.
  always_comb begin
    w_line_end  = (r_dot == DOT_LAST);
    w_xfer_exit = (r_done || render_done) && (r_dot >= DOT_XMIN);
    w_ndot      = '0;
    w_nly       = '0;
    if (r_run) begin
      w_ndot = w_line_end ? 9'd0 : r_dot + 9'd1;
      if (w_line_end)
        w_nly = (r_ly == LY_LAST) ? 8'd0 : r_ly + 8'd1;
      else
        w_nly = r_ly;
    end
    if (w_nly >= LY_VBL)
      w_nmode = VBLANK;
    else if (w_ndot < DOT_XFER)
      w_nmode = OAM;
    else if (w_ndot == DOT_XFER)
      w_nmode = XFER;
    else if ((r_mode == XFER) && !w_xfer_exit)
      w_nmode = XFER;
    else
      w_nmode = HBLANK;
  end

  always_ff @(posedge clk) begin
    if (reset || !lcd_enable) begin
      r_run        <= 1'b0;
      r_dot        <= '0;
      r_ly         <= '0;
      r_mode       <= HBLANK;
      r_done       <= 1'b0;
      r_drawline   <= 1'b0;
      r_vblank_irq <= 1'b0;
      r_vram_ok    <= 1'b1;
      r_oam_ok     <= 1'b1;
      r_overrun    <= 1'b0;
    end else begin
      r_run        <= 1'b1;
      r_dot        <= w_ndot;
      r_ly         <= w_nly;
      r_mode       <= w_nmode;
      r_drawline   <= (w_nmode == XFER) && (w_ndot == DOT_XFER);
      r_vblank_irq <= (w_nly == LY_VBL) && (w_ndot == 9'd0);
      r_vram_ok    <= (w_nmode != XFER);
      r_oam_ok     <= (w_nmode == HBLANK) || (w_nmode == VBLANK);
      if (w_ndot == 9'd0)
        r_done <= 1'b0;
      else if ((r_mode == XFER) && render_done)
        r_done <= 1'b1;
      if (r_run && (r_mode == XFER) && w_line_end)
        r_overrun <= 1'b1;
    end
    r_lyc_match <= (r_ly == lyc);
  end

  assign w_stat_clear = reset || !lcd_enable;

`ifdef WHIZ_STAT_IRQ_EN
  stat_irq_gen u_stat_irq_gen (
    .clk         (clk),
    .i_clear     (w_stat_clear),
    .i_stat_en   (stat_en),
    .i_mode      (r_mode),
    .i_lyc_match (r_lyc_match),
    .o_stat_irq  (stat_irq)
  );
`else
  logic w_unused_stat;
  assign w_unused_stat = ^{stat_en, w_stat_clear};
  assign stat_irq      = 1'b0;
`endif

  assign drawline    = r_drawline;
  assign ly          = r_ly;
  assign dot         = r_dot;
  assign mode        = r_mode;
  assign lyc_match   = r_lyc_match;
  assign vram_cpu_ok = r_vram_ok;
  assign oam_cpu_ok  = r_oam_ok;
  assign vblank_irq  = r_vblank_irq;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_lcd_mode_sequencer.sv
// Directed self-checking bench for lcd_mode_sequencer; line count shortened to keep frames small.
module tb_lcd_mode_sequencer;
  import video_types::*;

  localparam int unsigned VIS = 24;
  localparam int unsigned TOT = 28;

  logic       clk = 1'b0;
  logic       reset;
  logic       lcd_enable;
  logic [7:0] lyc;
  logic [3:0] stat_en;
  logic       render_done;
  logic       drawline;
  logic [7:0] ly;
  logic [8:0] dot;
  lcd_mode_t  mode;
  logic       lyc_match;
  logic       vram_cpu_ok;
  logic       oam_cpu_ok;
  logic       vblank_irq;
  logic       stat_irq;
  logic       overrun;

  int total = 0;
  int bad   = 0;
  int n_draw = 0;
  int n_vbl  = 0;
  int n_stat = 0;

  lcd_mode_sequencer #(
    .DOTS_PER_LINE (456),
    .OAM_DOTS      (80),
    .MIN_XFER_DOTS (172),
    .VISIBLE_LINES (VIS),
    .TOTAL_LINES   (TOT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .lcd_enable  (lcd_enable),
    .lyc         (lyc),
    .stat_en     (stat_en),
    .render_done (render_done),
    .drawline    (drawline),
    .ly          (ly),
    .dot         (dot),
    .mode        (mode),
    .lyc_match   (lyc_match),
    .vram_cpu_ok (vram_cpu_ok),
    .oam_cpu_ok  (oam_cpu_ok),
    .vblank_irq  (vblank_irq),
    .stat_irq    (stat_irq),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n_draw += int'(drawline);
    n_vbl  += int'(vblank_irq);
    n_stat += int'(stat_irq);
  endtask

  task automatic goto(input int tl, input int td);
    int k;
    logic hit;
    k = 0;
    while (!((int'(ly) == tl) && (int'(dot) == td)) && (k < 20000)) begin
      step();
      k++;
    end
    hit = (int'(ly) == tl) && (int'(dot) == td);
    chk($sformatf("reach_%0d_%0d", tl, td), 32'(hit), 32'd1);
  endtask

  initial begin
    reset = 1'b1; lcd_enable = 1'b0; lyc = 8'd20; stat_en = 4'b1000; render_done = 1'b1;
    step(); step();
    chk("rst_dot", 32'(dot), 32'd0);
    chk("rst_ly", 32'(ly), 32'd0);
    chk("rst_mode", 32'(mode), 32'(HBLANK));
    chk("rst_vram_ok", 32'(vram_cpu_ok), 32'd1);
    chk("rst_oam_ok", 32'(oam_cpu_ok), 32'd1);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_drawline", 32'(drawline), 32'd0);
    chk("rst_lyc_match", 32'(lyc_match), 32'd0);

    // line 0, render_done tied high
    reset = 1'b0; lcd_enable = 1'b1;
    n_draw = 0; n_vbl = 0; n_stat = 0;
    step();
    chk("l0_start_dot", 32'(dot), 32'd0);
    chk("l0_start_mode", 32'(mode), 32'(OAM));
    chk("l0_start_oam_ok", 32'(oam_cpu_ok), 32'd0);
    chk("l0_start_vram_ok", 32'(vram_cpu_ok), 32'd1);
    goto(0, 79);
    chk("l0_d79_mode", 32'(mode), 32'(OAM));
    chk("l0_d79_draw", 32'(drawline), 32'd0);
    step();
    chk("l0_d80_mode", 32'(mode), 32'(XFER));
    chk("l0_d80_draw", 32'(drawline), 32'd1);
    chk("l0_d80_vram_ok", 32'(vram_cpu_ok), 32'd0);
    chk("l0_d80_oam_ok", 32'(oam_cpu_ok), 32'd0);
    step();
    chk("l0_d81_draw", 32'(drawline), 32'd0);
    goto(0, 251);
    chk("l0_d251_mode", 32'(mode), 32'(XFER));
    step();
    chk("l0_d252_mode", 32'(mode), 32'(HBLANK));
    chk("l0_d252_vram_ok", 32'(vram_cpu_ok), 32'd1);
    chk("l0_d252_oam_ok", 32'(oam_cpu_ok), 32'd1);
    goto(1, 0);
    chk("l1_mode", 32'(mode), 32'(OAM));
    chk("l0_draw_count", 32'(n_draw), 32'd1);

    // line 5: render_done pulsed at dot 300
    goto(5, 0);
    render_done = 1'b0;
    goto(5, 300);
    chk("l5_d300_mode", 32'(mode), 32'(XFER));
    chk("l5_d300_vram_ok", 32'(vram_cpu_ok), 32'd0);
    render_done = 1'b1;
    step();
    render_done = 1'b0;
    chk("l5_d301_mode", 32'(mode), 32'(HBLANK));
    chk("l5_d301_vram_ok", 32'(vram_cpu_ok), 32'd1);

    // line 6: pulse during OAM is ignored
    goto(6, 40);
    render_done = 1'b1;
    step();
    render_done = 1'b0;
    goto(6, 400);
    chk("l6_d400_mode", 32'(mode), 32'(XFER));
    render_done = 1'b1;
    step();
    render_done = 1'b0;
    chk("l6_d401_mode", 32'(mode), 32'(HBLANK));

    // line 7: pulse on the drawline cycle is latched
    goto(7, 80);
    render_done = 1'b1;
    step();
    render_done = 1'b0;
    goto(7, 251);
    chk("l7_d251_mode", 32'(mode), 32'(XFER));
    step();
    chk("l7_d252_mode", 32'(mode), 32'(HBLANK));

    // line 10: render_done never arrives
    goto(8, 0);
    render_done = 1'b1;
    goto(10, 0);
    render_done = 1'b0;
    goto(10, 455);
    chk("l10_d455_mode", 32'(mode), 32'(XFER));
    chk("l10_d455_overrun", 32'(overrun), 32'd0);
    step();
    render_done = 1'b1;
    chk("l11_ly", 32'(ly), 32'd11);
    chk("l11_mode", 32'(mode), 32'(OAM));
    chk("l11_overrun", 32'(overrun), 32'd1);
    goto(11, 252);
    chk("l11_d252_mode", 32'(mode), 32'(HBLANK));
    goto(12, 0);
    chk("l12_overrun", 32'(overrun), 32'd1);

    // lyc = 20
    goto(19, 455);
    chk("pre_lyc_stat_count", 32'(n_stat), 32'd0);
    step();
    chk("l20_d0_lyc_match", 32'(lyc_match), 32'd0);
    step();
    chk("l20_d1_lyc_match", 32'(lyc_match), 32'd1);
    step();
`ifdef WHIZ_STAT_IRQ_EN
    chk("l20_d2_stat_irq", 32'(stat_irq), 32'd1);
`else
    chk("l20_d2_stat_irq", 32'(stat_irq), 32'd0);
`endif
    n_stat = 0;
    goto(21, 0);
    chk("l20_stat_count", 32'(n_stat), 32'd0);
    step();
    chk("l21_d1_lyc_match", 32'(lyc_match), 32'd0);

    // vblank
    goto(VIS - 1, 455);
    chk("pre_vbl_count", 32'(n_vbl), 32'd0);
    step();
    chk("vbl_ly", 32'(ly), 32'(VIS));
    chk("vbl_mode", 32'(mode), 32'(VBLANK));
    chk("vbl_irq", 32'(vblank_irq), 32'd1);
    chk("vbl_oam_ok", 32'(oam_cpu_ok), 32'd1);
    n_draw = 0; n_vbl = 0;
    step();
    chk("vbl_irq_d1", 32'(vblank_irq), 32'd0);
    goto(TOT - 1, 455);
    chk("vbl_last_mode", 32'(mode), 32'(VBLANK));
    chk("vbl_draw_count", 32'(n_draw), 32'd0);
    chk("vbl_irq_count", 32'(n_vbl), 32'd0);
    step();
    chk("wrap_ly", 32'(ly), 32'd0);
    chk("wrap_mode", 32'(mode), 32'(OAM));
    chk("wrap_overrun", 32'(overrun), 32'd1);

    // disable mid-line then re-enable
    goto(22, 200);
    lcd_enable = 1'b0;
    step();
    chk("dis_ly", 32'(ly), 32'd0);
    chk("dis_dot", 32'(dot), 32'd0);
    chk("dis_mode", 32'(mode), 32'(HBLANK));
    chk("dis_vram_ok", 32'(vram_cpu_ok), 32'd1);
    chk("dis_oam_ok", 32'(oam_cpu_ok), 32'd1);
    chk("dis_overrun", 32'(overrun), 32'd0);
    step();
    chk("dis_hold_dot", 32'(dot), 32'd0);
    lcd_enable = 1'b1;
    step();
    chk("reen_mode", 32'(mode), 32'(OAM));
    chk("reen_dot", 32'(dot), 32'd0);
    goto(0, 80);
    chk("reen_draw", 32'(drawline), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_mode_sequencer.md
Name: lcd_mode_sequencer

Overview:
- Timing and mode controller for the whizgraphics renderer.
- Generates dot and line counters and the LCD mode sequence (OAM scan, transfer, HBlank, VBlank).
- Issues one drawline request per visible line and waits for renderComplete.
- Gates CPU access to VRAM/OAM and raises VBlank/STAT interrupts.
- Sits between the CPU DataBus register block and the line renderer.

Parameters:
- DOTS_PER_LINE, 456, dots per scanline.
- OAM_DOTS, 80, mode-2 length.
- MIN_XFER_DOTS, 172, minimum mode-3 length.
- VISIBLE_LINES, 144, rendered lines per frame.
- TOTAL_LINES, 154, lines per frame including VBlank.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- lcd_enable  in  1  LCDC bit 7; low holds sequencer idle.
- lyc  in  8  LY compare value.
- stat_en  in  4  STAT source enables {lyc, oam, vblank, hblank}.
- render_done  in  1  renderComplete from renderer; level or pulse.
- drawline  out  1  one-cycle render request.
- ly  out  8  current line.
- dot  out  9  dot within line.
- mode  out  2  lcd_mode_t.
- lyc_match  out  1  ly == lyc.
- vram_cpu_ok  out  1  CPU may access VRAM.
- oam_cpu_ok  out  1  CPU may access OAM.
- vblank_irq  out  1  one-cycle pulse.
- stat_irq  out  1  one-cycle pulse.
- overrun  out  1  sticky: renderer missed the line.

Behaviour:
- All outputs are registered.
- Reset or lcd_enable=0 forces: dot=0, ly=0, mode=HBLANK, drawline=0, irqs=0, overrun=0, vram_cpu_ok=1, oam_cpu_ok=1. lyc_match still tracks (0==lyc).
- Reset dominates lcd_enable; mid-line reset or disable aborts immediately.
- Enable rise: next cycle starts line 0, dot 0, mode OAM.
- dot increments every cycle, 0..DOTS_PER_LINE-1, then wraps to 0 and ly increments. ly wraps TOTAL_LINES-1 -> 0. Line length is fixed regardless of renderer.
- Visible line (ly < VISIBLE_LINES):
  - dot 0..OAM_DOTS-1: mode=OAM.
  - dot == OAM_DOTS: mode=XFER and drawline=1 for exactly that cycle.
  - XFER holds until render_done has been seen (latched from the drawline cycle onward; same-cycle counts) AND dot >= OAM_DOTS+MIN_XFER_DOTS-1.
  - Next cycle: mode=HBLANK. Earliest HBLANK dot is 252 at defaults.
  - render_done outside XFER is ignored; the latch clears at line start.
- Timeout: XFER still active at dot DOTS_PER_LINE-1 -> overrun<=1 (sticky until reset or disable). Next line proceeds normally.
- ly >= VISIBLE_LINES: mode=VBLANK for the whole line; no drawline.
- vblank_irq: pulse on the first cycle ly==VISIBLE_LINES (dot 0).
- Access gating:
  - vram_cpu_ok = (mode != XFER).
  - oam_cpu_ok = (mode == HBLANK || mode == VBLANK).
- lyc_match: registered ly==lyc; updates the cycle after ly changes.

Optional Feature:
- Macro: WHIZ_STAT_IRQ_EN.
- Defined:
  - stat_line = (stat_en[0] & HBLANK) | (stat_en[1] & VBLANK) | (stat_en[2] & OAM) | (stat_en[3] & lyc_match).
  - stat_irq pulses one cycle on a stat_line rising edge only. A continuous-high STAT line across a mode change gives no new pulse.
- Undefined: stat_irq tied 0; stat_en is unused.

Decomposition:
- video_types package:
  - lcd_mode_t enum (HBLANK=0, VBLANK=1, OAM=2, XFER=3).
  - Default timing constants.
- Sub-module stat_irq_gen: STAT OR-combine plus rising-edge detector. Instantiated only under WHIZ_STAT_IRQ_EN.

Test Plan:
- Reset 1 cycle, enable=1, render_done tied 1 -> ly=0, OAM dots 0-79, drawline only at dot 80, HBLANK from dot 252, ly=1 at next dot 0.
- render_done pulsed at dot 300 of line 5 -> XFER through dot 300, HBLANK at dot 301, vram_cpu_ok low 80..300.
- Run a full frame -> vblank_irq single pulse at ly=144 dot 0, VBLANK lines 144-153, ly 153->0, no drawline during VBLANK.
- render_done never asserted on line 10 -> XFER through dot 455, overrun=1 and stays, line 11 starts OAM at dot 0.
- WHIZ_STAT_IRQ_EN, lyc=20, stat_en=4'b1000 -> one stat_irq when lyc_match rises during line 20; none while it stays high.
- lcd_enable dropped at ly=50 dot 200 -> next cycle ly=0, dot=0, HBLANK, all ok flags 1; re-enable restarts line 0 OAM.
